// File: rtl/egress_desc_queue.sv
// Per-port egress descriptor queue: circular buffer feeding an offer/busy reader FSM.
// Optional saturating drop counter enabled by defining EGRESS_DROP_CNT_EN.
package mem_pkg;
   localparam int ADDR_W = 12;
endpackage

module egress_desc_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = mem_pkg::ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       write_req_i,
   input  logic [ADDR_W-1:0]          start_ptr_i,
   input  logic                       flush_i,
   output logic                       desc_valid_o,
   output logic [ADDR_W-1:0]          desc_ptr_o,
   input  logic                       desc_ready_i,
   input  logic                       frame_done_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       overflow_o
`ifdef EGRESS_DROP_CNT_EN
  ,output logic [15:0]                drop_count_o
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, cnt_nxt;
   logic              is_full, do_enq, do_deq, drop;

   assign is_full = (count == FULL_CNT);
   assign do_enq  = write_req_i && !is_full;
   assign do_deq  = (state == OFFER) && desc_ready_i;
   assign drop    = write_req_i && is_full;

   always_comb begin
      cnt_nxt = count;
      if (do_enq && !do_deq)
         cnt_nxt = count + CW'(1);
      else if (!do_enq && do_deq)
         cnt_nxt = count - CW'(1);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cnt_nxt != '0)
               state_nxt = OFFER;
         end
         OFFER: begin
            if (desc_ready_i)
               state_nxt = BUSY;
         end
         BUSY: begin
            if (frame_done_i)
               state_nxt = (cnt_nxt != '0) ? OFFER : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Flush wins over every other update, including a same-cycle enqueue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else if (flush_i) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= cnt_nxt;
         overflow_o <= drop;
         if (do_enq)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_deq)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq && !flush_i)
         mem[wr_ptr] <= start_ptr_i;
   end

`ifdef EGRESS_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count_o <= '0;
      else if (drop && !flush_i && drop_count_o != 16'hFFFF)
         drop_count_o <= drop_count_o + 16'd1;
   end
`endif

   assign desc_valid_o = (state == OFFER);
   assign desc_ptr_o   = mem[rd_ptr];
   assign count_o      = count;
   assign full_o       = is_full;
   assign empty_o      = (count == '0);

endmodule

// File: tb/tb_egress_desc_queue.sv
// Directed bench for egress_desc_queue (DEPTH=8, ADDR_W=12).
// Drop-counter steps run only when EGRESS_DROP_CNT_EN is defined.
module tb_egress_desc_queue;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          write_req_i;
   logic [AW-1:0] start_ptr_i;
   logic          flush_i;
   logic          desc_valid_o;
   logic [AW-1:0] desc_ptr_o;
   logic          desc_ready_i;
   logic          frame_done_i;
   logic [3:0]    count_o;
   logic          full_o;
   logic          empty_o;
   logic          overflow_o;
`ifdef EGRESS_DROP_CNT_EN
   logic [15:0]   drop_count_o;
`endif

   int total = 0;
   int pass  = 0;

   egress_desc_queue #(.DEPTH(8), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_req_i  (write_req_i),
      .start_ptr_i  (start_ptr_i),
      .flush_i      (flush_i),
      .desc_valid_o (desc_valid_o),
      .desc_ptr_o   (desc_ptr_o),
      .desc_ready_i (desc_ready_i),
      .frame_done_i (frame_done_i),
      .count_o      (count_o),
      .full_o       (full_o),
      .empty_o      (empty_o),
      .overflow_o   (overflow_o)
`ifdef EGRESS_DROP_CNT_EN
     ,.drop_count_o (drop_count_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] p);
      write_req_i = 1'b1;
      start_ptr_i = p;
      step();
      write_req_i = 1'b0;
   endtask

   task automatic accept();
      desc_ready_i = 1'b1;
      step();
      desc_ready_i = 1'b0;
   endtask

   task automatic done();
      frame_done_i = 1'b1;
      step();
      frame_done_i = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      write_req_i  = 1'b0;
      start_ptr_i  = '0;
      flush_i      = 1'b0;
      desc_ready_i = 1'b0;
      frame_done_i = 1'b0;
      #12;
      chk("rst_valid", 32'(desc_valid_o), 0);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_empty", 32'(empty_o), 1);
      chk("rst_full", 32'(full_o), 0);
      chk("rst_ovf", 32'(overflow_o), 0);
`ifdef EGRESS_DROP_CNT_EN
      chk("rst_drop", 32'(drop_count_o), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single push, accept, done
      push(12'h010);
      chk("p1_valid", 32'(desc_valid_o), 1);
      chk("p1_ptr", 32'(desc_ptr_o), 32'h010);
      chk("p1_count", 32'(count_o), 1);
      accept();
      chk("p1_busy_valid", 32'(desc_valid_o), 0);
      chk("p1_busy_count", 32'(count_o), 0);
      chk("p1_busy_empty", 32'(empty_o), 1);
      done();
      chk("p1_idle_valid", 32'(desc_valid_o), 0);

      // fill to full, 9th dropped
      for (int i = 1; i <= 8; i++) push(AW'(i));
      chk("fill_full", 32'(full_o), 1);
      chk("fill_count", 32'(count_o), 8);
      chk("fill_ovf0", 32'(overflow_o), 0);
      push(12'h009);
      chk("drop_ovf", 32'(overflow_o), 1);
      chk("drop_count", 32'(count_o), 8);
      chk("drop_head", 32'(desc_ptr_o), 1);
      step();
      chk("drop_ovf_once", 32'(overflow_o), 0);
`ifdef EGRESS_DROP_CNT_EN
      chk("drop_cnt1", 32'(drop_count_o), 1);
`endif
      // frame_done outside BUSY is ignored
      done();
      chk("done_ign_valid", 32'(desc_valid_o), 1);
      chk("done_ign_count", 32'(count_o), 8);
      // drain in order
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain_v%0d", i), 32'(desc_valid_o), 1);
         chk($sformatf("drain_p%0d", i), 32'(desc_ptr_o), i);
         accept();
         done();
      end
      chk("drain_idle", 32'(desc_valid_o), 0);
      chk("drain_empty", 32'(empty_o), 1);

      // two queued, back-to-back frames
      push(12'h00A);
      push(12'h00B);
      chk("ab_head", 32'(desc_ptr_o), 32'h00A);
      accept();
      chk("ab_count", 32'(count_o), 1);
      done();
      chk("ab_valid_b", 32'(desc_valid_o), 1);
      chk("ab_ptr_b", 32'(desc_ptr_o), 32'h00B);
      accept();
      done();
      chk("ab_idle", 32'(desc_valid_o), 0);
      chk("ab_empty", 32'(empty_o), 1);

      // wrap-around ordering
      for (int i = 0; i < 20; i++) begin
         push(AW'(12'h100 + i));
         chk($sformatf("wrap_p%0d", i), 32'(desc_ptr_o), 32'h100 + i);
         accept();
         done();
      end
      chk("wrap_empty", 32'(empty_o), 1);

      // full with simultaneous dequeue still drops
      for (int i = 0; i < 8; i++) push(AW'(12'h200 + i));
      write_req_i  = 1'b1;
      start_ptr_i  = 12'h2FF;
      desc_ready_i = 1'b1;
      step();
      write_req_i  = 1'b0;
      desc_ready_i = 1'b0;
      chk("fdq_ovf", 32'(overflow_o), 1);
      chk("fdq_count", 32'(count_o), 7);
`ifdef EGRESS_DROP_CNT_EN
      chk("fdq_drop_cnt", 32'(drop_count_o), 2);
`endif
      done();
      chk("fdq_next", 32'(desc_ptr_o), 32'h201);

      // simultaneous enqueue/dequeue below full, then flush
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int i = 0; i < 4; i++) push(AW'(12'h021 + i));
      write_req_i  = 1'b1;
      start_ptr_i  = 12'h025;
      desc_ready_i = 1'b1;
      step();
      write_req_i  = 1'b0;
      desc_ready_i = 1'b0;
      chk("enqdeq_count", 32'(count_o), 4);
      chk("enqdeq_busy", 32'(desc_valid_o), 0);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush_count", 32'(count_o), 0);
      chk("flush_valid", 32'(desc_valid_o), 0);
      chk("flush_empty", 32'(empty_o), 1);
      done();
      chk("flush_done_ign", 32'(desc_valid_o), 0);
      chk("flush_done_cnt", 32'(count_o), 0);
      push(12'h030);
      chk("post_flush_ptr", 32'(desc_ptr_o), 32'h030);
      accept();
      done();

`ifdef EGRESS_DROP_CNT_EN
      for (int i = 0; i < 8; i++) push(AW'(i));
      write_req_i = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      write_req_i = 1'b0;
      chk("drop_sat", 32'(drop_count_o), 32'hFFFF);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("drop_keep_flush", 32'(drop_count_o), 32'hFFFF);
`endif

      // reset mid-frame acts immediately
      push(12'h040);
      push(12'h041);
      push(12'h042);
      accept();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(desc_valid_o), 0);
      chk("arst_count", 32'(count_o), 0);
      chk("arst_empty", 32'(empty_o), 1);
      chk("arst_full", 32'(full_o), 0);
      chk("arst_ovf", 32'(overflow_o), 0);
`ifdef EGRESS_DROP_CNT_EN
      chk("arst_drop", 32'(drop_count_o), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      done();
      chk("arst_done_ign", 32'(desc_valid_o), 0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
